// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router input port.
// Buffers client payload, then sends header, payload and parity under busy.
module router_pkt_tx #(
  parameter int FIFO_DEPTH = 64,
  parameter int GAP_CYCLES = 2,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = $clog2(FIFO_DEPTH + 1),
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          pl_valid,
  input  logic [7:0]    pl_data,
  output logic          pl_ready,
  input  logic          req_valid,
  input  logic [1:0]    req_addr,
  input  logic [5:0]    req_len,
  output logic          req_ready,
  input  logic          busy,
  output logic          pkt_valid,
  output logic [7:0]    data_out,
  output logic          req_err,
  output logic          tx_done,
  output logic [CW-1:0] fifo_count
);

  typedef enum logic [2:0] {
    IDLE, HEADER, PAYLOAD, PARITY, GAP
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt_q;
  logic [7:0]    dout_q, dout_d;
  logic [7:0]    par_q, par_d;
  logic [5:0]    rem_q, rem_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          pv_q, pv_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic          push, pop;
  logic [7:0]    head, hdr;

  assign pl_ready   = (cnt_q != CW'(FIFO_DEPTH));
  assign push       = pl_valid & pl_ready;
  assign head       = mem[rd_ptr];
  assign hdr        = {req_len, req_addr};
  assign pkt_valid  = pv_q;
  assign data_out   = dout_q;
  assign req_err    = err_q;
  assign tx_done    = done_q;
  assign fifo_count = cnt_q;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= pl_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      dout_q  <= '0;
      par_q   <= '0;
      rem_q   <= '0;
      gap_q   <= '0;
      pv_q    <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      par_q   <= par_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      pv_q    <= pv_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dout_d    = dout_q;
    par_d     = par_q;
    rem_d     = rem_q;
    gap_d     = gap_q;
    pv_d      = pv_q;
    err_d     = 1'b0;
    done_d    = 1'b0;
    pop       = 1'b0;
    req_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = (cnt_q >= CW'(req_len));
        if (req_valid && req_ready) begin
          if (req_addr == 2'd3) begin
            err_d = 1'b1;
          end else begin
            dout_d  = hdr;
            pv_d    = 1'b1;
            par_d   = hdr;
            rem_d   = req_len;
            state_d = HEADER;
          end
        end
      end
      // rem counts bytes still to pop; header and payload share the step
      HEADER, PAYLOAD: begin
        if (!busy) begin
          if (rem_q == 6'd0) begin
            dout_d  = par_q;
            pv_d    = 1'b0;
            state_d = PARITY;
          end else begin
            pop     = 1'b1;
            dout_d  = head;
            par_d   = par_q ^ head;
            rem_d   = rem_q - 6'd1;
            state_d = PAYLOAD;
          end
        end
      end
      PARITY: begin
        if (!busy) begin
          done_d = 1'b1;
          dout_d = '0;
          gap_d  = '0;
          if (GAP_CYCLES == 0) state_d = IDLE;
          else                 state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) state_d = IDLE;
        else                              gap_d   = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
